// File: rtl/escalonador_pedidos_if.sv
`default_nettype none
// ============================================================================
// Module      : escalonador_pedidos_if
// Description : Bundle of order-panel and coffee-machine signals around the
//               round-robin order scheduler.
//               slave  modport : scheduler view (drives grant/done/start...)
//               master modport : panels + machine view (drives req/state)
// Ports       : req[N_REQ], grant[N_REQ], done, done_id, busy,
//               machine_start, machine_state[4], cup_count[CNT_W], error
// Revision    : 1.0 - initial release
// ============================================================================
interface escalonador_pedidos_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic             done;
    logic [ID_W-1:0]  done_id;
    logic             busy;
    logic             machine_start;
    logic [3:0]       machine_state;
    logic [CNT_W-1:0] cup_count;
    logic             error;

    modport slave (
        input  req, machine_state,
        output grant, done, done_id, busy, machine_start, cup_count, error
    );

    modport master (
        output req, machine_state,
        input  grant, done, done_id, busy, machine_start, cup_count, error
    );
endinterface
`default_nettype wire

// File: rtl/escalonador_pedidos.sv
`default_nettype none
// ============================================================================
// Module      : escalonador_pedidos
// Description : Round-robin order scheduler sharing one coffee machine among
//               N_REQ order panels. Grants one panel, pulses the machine
//               start, follows the machine state code until extraction, then
//               reports completion and a saturating cup count.
// Ports       : clk, rst (async, active high)
//               bus (escalonador_pedidos_if.slave): req in, machine_state in,
//               grant/done/done_id/busy/machine_start/cup_count/error out
// Options     : ESCALONADOR_WATCHDOG_EN - abort a stalled brew after TIMEOUT
//               cycles and raise a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module escalonador_pedidos #(
    parameter int N_REQ   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  wire logic               clk,
    input  wire logic               rst,
    escalonador_pedidos_if.slave    bus
);
    localparam int ID_W = $clog2(N_REQ);

    localparam logic [3:0] C_MS_LIGAR    = 4'd2;
    localparam logic [3:0] C_MS_EXTRACAO = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cup_q, cup_d;

    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_ptr_next;

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && bus.req[(int'(ptr_q) + k) % N_REQ]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    // The served requester becomes the lowest priority for the next round.
    assign w_ptr_next = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

`ifdef ESCALONADOR_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        grant_d = grant_q;
        start_d = start_q;
        done_d  = 1'b0;
        cup_d   = cup_q;
`ifdef ESCALONADOR_WATCHDOG_EN
        wd_d    = wd_q;
        error_d = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    grant_d = N_REQ'(1) << w_winner;
                    id_d    = w_winner;
                    start_d = 1'b1;
                    state_d = S_START;
`ifdef ESCALONADOR_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end
            end
            S_START: begin
                if (bus.machine_state == C_MS_LIGAR) begin
                    start_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Count and done are updated on entry so they show up
                // together with the FINISH-cycle done pulse.
                if (bus.machine_state == C_MS_EXTRACAO) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                    ptr_d   = w_ptr_next;
                    if (cup_q != {CNT_W{1'b1}}) begin
                        cup_d = cup_q + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef ESCALONADOR_WATCHDOG_EN
        // Stalled brew: abandon it without a done pulse or cup increment.
        if (state_q == S_START || state_q == S_RUN) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT)) begin
                state_d = S_IDLE;
                grant_d = '0;
                start_d = 1'b0;
                done_d  = 1'b0;
                cup_d   = cup_q;
                error_d = 1'b1;
                ptr_d   = w_ptr_next;
                wd_d    = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            grant_q <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            cup_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            grant_q <= grant_d;
            start_q <= start_d;
            done_q  <= done_d;
            cup_q   <= cup_d;
        end
    end

`ifdef ESCALONADOR_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end
    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.grant         = grant_q;
    assign bus.done          = done_q;
    assign bus.done_id       = id_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.machine_start = start_q;
    assign bus.cup_count     = cup_q;

endmodule
`default_nettype wire
